trans_framer: RTL
=================

Name: trans_framer

Overview:
- Upstream stage of the transaction validator.
- Assembles a byte-serial transaction stream into 128-bit transaction words: sender_id[127:80], receiver_id[79:32], amount[31:10], block-start bit 9, bits [8:0] passed through.
- Buffers complete words in a small FIFO.
- Presents the FIFO head to the validator with a valid/ack handshake: valid held until ack, ack arrives as a 1-cycle pulse one cycle after the validator latches the word.

Parameters:
FIFO_DEPTH, 4, number of buffered 128-bit words; power of 2, minimum 2
BIT_BLOCK_START, 9, bit of the transaction word forced to 1 for the first transaction of a block
CNT_WIDTH, 16, width of the frame counter

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
byte_i  input  8  transaction byte; byte 0 is data[127:120], byte 15 is data[7:0]
byte_valid_i  input  1  byte_i valid
byte_ready_o  output  1  framer can accept a byte; transfer on byte_valid_i & byte_ready_o
sob_i  input  1  start-of-block flag, qualified with the transferred byte at index 0
data_o  output  128  FIFO head transaction word
valid_o  output  1  data_o holds a transaction; stays high until ack_i
ack_i  input  1  1-cycle pulse from validator; pops the FIFO head
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_count_o  output  CNT_WIDTH  number of words pushed since reset, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, rst=1): byte index 0, shift register 0, sob latch 0, FIFO pointers 0, level 0.
  - Outputs: valid_o=0, data_o=0, byte_ready_o=0 while rst is high, fifo_level_o=0, frame_count_o=0.
  - Reset mid-frame discards the partial word. Reset with valid_o high drops all buffered words.
- Assembly:
  - 4-bit byte index counter advances on each transfer and wraps 15->0.
  - The byte at index k is written to bits [127-8k -: 8].
  - On a transfer at index 0, sob latch <= sob_i. sob_i at any other index is ignored.
- Push: on the transfer at index 15, the completed word is written to the FIFO with bit BIT_BLOCK_START = received bit | sob latch; all other bits pass through unmodified. The push also increments frame_count_o.
- byte_ready_o = !rst && (fifo_level_o != FIFO_DEPTH).
  - While the FIFO is full, bytes at any index are stalled, never dropped.
  - A partial word is held indefinitely across stalls.
- Output:
  - valid_o = (level != 0).
  - data_o = mem[rd_ptr], taken from registered storage; data_o is stable while valid_o is high.
  - Latency: with the FIFO empty, the 16th byte transferred at edge N gives valid_o=1 after edge N.
- Pop:
  - ack_i high with valid_o high at an edge advances rd_ptr and decrements level.
  - ack_i with valid_o low is ignored; it does not underflow.
  - A word is never presented twice after its ack.
- Simultaneous push and pop: level is unchanged and both pointers advance. Full plus pop in the same cycle: no push can occur, because byte_ready_o was low in that cycle.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Level is kept as a separate counter.
- No timeout and no word-level error detection; framing relies solely on the byte count from reset.

Test Plan:
- Reset, then 16 bytes 0x00..0x0F with sob_i=0 at byte 0 -> one cycle after the last byte, valid_o=1, data_o=0x000102030405060708090A0B0C0D0E0F, frame_count_o=1.
- Same bytes with sob_i=1 at byte 0 -> data_o=0x000102030405060708090A0B0C0D0E0F with bit 9 set (byte 14 = 0x0E, already bit 1 set; repeat with byte 14 = 0x00 -> data_o[15:8]=0x02). sob_i=1 at byte 5 only -> bit 9 unchanged.
- Handshake: hold ack_i=0 for 10 cycles -> valid_o and data_o stable. Pulse ack_i for 1 cycle -> next cycle valid_o=0 with FIFO otherwise empty. ack_i pulsed while valid_o=0 -> fifo_level_o stays 0.
- Fill 4 words with ack_i=0 -> fifo_level_o=4, byte_ready_o=0, byte 0 of word 5 stalled. Ack once -> byte_ready_o=1. The 5 words pop in order with IDs intact.
- Continuous byte stream with ack_i pulsed every 17 cycles -> simultaneous push/pop cycles keep the level constant; 100 words received in order with no loss or duplication; frame_count_o=100.
- Assert rst after byte 7 of a word with 2 words buffered -> valid_o=0 and fifo_level_o=0 immediately (async). A new 16-byte word after release is framed from byte index 0.

Source files
------------

// File: rtl/trans_framer.sv
// rtl/trans_framer.sv - byte-serial to 128-bit transaction word framer with output FIFO
module trans_framer #(
   parameter int FIFO_DEPTH      = 4,
   parameter int BIT_BLOCK_START = 9,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    byte_i,
   input  logic                          byte_valid_i,
   output logic                          byte_ready_o,
   input  logic                          sob_i,
   output logic [127:0]                  data_o,
   output logic                          valid_o,
   input  logic                          ack_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic [CNT_WIDTH-1:0]          frame_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]     LVL_ONE  = LVL_W'(1);
   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   // Assembly state
   logic [3:0]   idx_q, idx_d;
   logic [127:0] shift_q, shift_d;
   logic         sob_q, sob_d;

   // FIFO state; level is a separate counter so full and empty are unambiguous
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [127:0]         mem_q [FIFO_DEPTH];

   logic         xfer;
   logic         push;
   logic         pop;
   logic [127:0] word;

   // Ready drops while in reset and whenever the FIFO is full; bytes stall, never drop
   assign byte_ready_o = !rst && (level_q != LVL_FULL);
   assign xfer         = byte_valid_i && byte_ready_o;
   assign push         = xfer && (idx_q == 4'd15);
   assign pop          = ack_i && (level_q != '0);

   assign valid_o       = (level_q != '0);
   assign data_o        = mem_q[rd_ptr_q];
   assign fifo_level_o  = level_q;
   assign frame_count_o = count_q;

   // Place each transferred byte at its slot; byte k lands at [127-8k -: 8]
   always_comb begin
      idx_d   = idx_q;
      shift_d = shift_q;
      sob_d   = sob_q;
      if (xfer) begin
         idx_d = idx_q + 4'd1;
         shift_d[{~idx_q, 3'b111} -: 8] = byte_i;
         if (idx_q == 4'd0) begin
            sob_d = sob_i;
         end
      end
      // The completed word includes the byte arriving this cycle; OR in the block-start flag
      word                  = shift_d;
      word[BIT_BLOCK_START] = shift_d[BIT_BLOCK_START] | sob_q;
   end

   // Pointer, level and frame counter next-state; push and pop together leave level unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         count_d  = count_q + CNT_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         level_d = level_q + LVL_ONE;
      end else if (pop && !push) begin
         level_d = level_q - LVL_ONE;
      end
   end

   // Control registers; reset discards any partial word and all buffered words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         shift_q  <= '0;
         sob_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         count_q  <= '0;
      end else begin
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         sob_q    <= sob_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         count_q  <= count_d;
      end
   end

   // Word storage; cleared on reset so data_o reads zero out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= word;
      end
   end

endmodule
